// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// button_conditioner: synchronises, debounces and auto-repeats one push-button,
// emitting an active-low pulse per event. Auto-repeat is built only with the
// AUTOREPEAT_EN macro defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int PULSE_CYCLES    = 2,
    parameter int CNT_WIDTH       = 25
) (
    input  logic MCLK,
    input  logic resetSignal,
    input  logic btnRaw,
    output logic pulseOut,
    output logic pressed,
    output logic repeating
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [CNT_WIDTH-1:0] c_db_last    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one    = CNT_WIDTH'(1);
    localparam logic [PW-1:0]        c_pulse_load = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0]        c_pulse_one  = PW'(1);

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] c_delay_last  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] c_period_last = CNT_WIDTH'(REPEAT_PERIOD - 1);
`else
    localparam int c_unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_HELD       = 3'd2,
        S_RELEASE_DB = 3'd3
`ifdef AUTOREPEAT_EN
        ,S_REPEAT    = 3'd4
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic                   pulse_req;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // All state updates on the falling edge of MCLK.
    always_ff @(negedge MCLK or negedge resetSignal) begin
        if (!resetSignal) begin
            sync_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btnRaw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + c_cnt_one;
        pulse_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (btn_sync) state_d = S_PRESS_DB;
            end
            S_PRESS_DB: begin
                if (!btn_sync) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_db_last) begin
                    state_d   = S_HELD;
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end
            end
            S_HELD: begin
                if (!btn_sync) begin
                    state_d = S_RELEASE_DB;
                    cnt_d   = '0;
`ifdef AUTOREPEAT_EN
                end else if (cnt_q == c_delay_last) begin
                    state_d   = S_REPEAT;
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
`ifdef AUTOREPEAT_EN
            S_REPEAT: begin
                if (!btn_sync) begin
                    state_d = S_RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == c_period_last) begin
                    cnt_d     = '0;
                    pulse_req = 1'b1;
                end
            end
`endif
            S_RELEASE_DB: begin
                // A bounce back to 1 resumes the hold without a new pulse.
                if (btn_sync) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == c_db_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Requests arriving while a pulse is still running are dropped.
    always_comb begin
        pcnt_d = pcnt_q;
        if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - c_pulse_one;
        end else if (pulse_req) begin
            pcnt_d = c_pulse_load;
        end
    end

    assign pulseOut = (pcnt_q == '0);

`ifdef AUTOREPEAT_EN
    assign pressed   = (state_q == S_HELD) || (state_q == S_REPEAT) || (state_q == S_RELEASE_DB);
    assign repeating = (state_q == S_REPEAT);
`else
    assign pressed   = (state_q == S_HELD) || (state_q == S_RELEASE_DB);
    assign repeating = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
//------------------------------------------------------------------------------
// tb_button_conditioner: directed scenarios plus randomized button activity,
// compared each cycle against a rule-level model of the conditioner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int PC   = 2;

`ifdef AUTOREPEAT_EN
    localparam bit AR     = 1'b1;
    localparam int RST_AT = 26;
`else
    localparam bit AR     = 1'b0;
    localparam int RST_AT = 6;
`endif

    logic MCLK;
    logic resetSignal;
    logic btnRaw;
    logic pulseOut;
    logic pressed;
    logic repeating;

    int n_checks;
    int n_errors;
    bit cmp_en;

    button_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .PULSE_CYCLES   (PC),
        .CNT_WIDTH      (5)
    ) dut (
        .MCLK       (MCLK),
        .resetSignal(resetSignal),
        .btnRaw     (btnRaw),
        .pulseOut   (pulseOut),
        .pressed    (pressed),
        .repeating  (repeating)
    );

    initial MCLK = 1'b1;
    always #5 MCLK = ~MCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: run lengths of the synchronised level and ages since
    // the last accepted event, rather than an explicit state machine.
    typedef struct packed {
        logic [SYNC-1:0] hist;
        int              run;
        int              zrun;
        int              age;
        int              pl;
        logic            prs;
        logic            rep;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.hist = '0; r.run = 0; r.zrun = 0; r.age = 0; r.pl = 0;
        r.prs = 1'b0; r.rep = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_step(mstate_t c, logic raw);
        mstate_t n;
        logic    s;
        logic    req;
        n      = c;
        req    = 1'b0;
        s      = c.hist[SYNC-1];
        n.hist = {c.hist[SYNC-2:0], raw};
        if (!c.prs) begin
            if (s) begin
                n.run = c.run + 1;
                if (n.run == DB + 1) begin
                    n.prs = 1'b1; n.run = 0; n.age = 0; req = 1'b1;
                end
            end else begin
                n.run = 0;
            end
        end else if (!s) begin
            n.rep  = 1'b0;
            n.zrun = c.zrun + 1;
            if (n.zrun == DB + 1) begin
                n.prs = 1'b0; n.zrun = 0;
            end
        end else if (c.zrun > 0) begin
            n.zrun = 0; n.age = 0;
        end else if (AR) begin
            n.age = c.age + 1;
            if (!c.rep && n.age == RD) begin
                n.rep = 1'b1; n.age = 0; req = 1'b1;
            end else if (c.rep && n.age == RP) begin
                n.age = 0; req = 1'b1;
            end
        end
        if (c.pl > 0)  n.pl = c.pl - 1;
        else if (req)  n.pl = PC;
        return n;
    endfunction

    always @(negedge MCLK or negedge resetSignal) begin
        if (!resetSignal) m <= model_reset();
        else              m <= model_step(m, btnRaw);
    end

    always @(posedge MCLK) begin
        if (cmp_en) begin
            check_eq("model_pulseOut", {31'd0, pulseOut}, {31'd0, m.pl == 0});
            check_eq("model_pressed", {31'd0, pressed}, {31'd0, m.prs});
            check_eq("model_repeating", {31'd0, repeating}, {31'd0, m.rep});
        end
    end

    function automatic logic exp_low_hold(int e);
        if (e == 6 || e == 7) return 1'b1;
        if (AR && e >= 26 && ((e - 26) % RP) < PC) return 1'b1;
        return 1'b0;
    endfunction

    task automatic settle(input logic v, input int n);
        btnRaw = v;
        repeat (n) @(posedge MCLK);
    endtask

    task automatic pulse_reset();
        #2 resetSignal = 1'b0;
        #1;
        check_eq("rst_pulseOut", {31'd0, pulseOut}, 32'd1);
        check_eq("rst_pressed", {31'd0, pressed}, 32'd0);
        check_eq("rst_repeating", {31'd0, repeating}, 32'd0);
        @(posedge MCLK);
        #2 resetSignal = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cmp_en      = 1'b0;
        btnRaw      = 1'b0;
        resetSignal = 1'b1;
        #1 resetSignal = 1'b0;
        #1;
        check_eq("init_pulseOut", {31'd0, pulseOut}, 32'd1);
        check_eq("init_pressed", {31'd0, pressed}, 32'd0);
        check_eq("init_repeating", {31'd0, repeating}, 32'd0);
        cmp_en = 1'b1;
        repeat (3) @(posedge MCLK);
        #2 resetSignal = 1'b1;
        settle(1'b0, 10);

        // Clean press held for 15 edges, then released.
        btnRaw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge MCLK);
            check_eq("clean_pulse", {31'd0, pulseOut}, {31'd0, !(k - 1 == 6 || k - 1 == 7)});
            check_eq("clean_pressed", {31'd0, pressed}, {31'd0, (k - 1 >= 6) && (k - 1 < 21)});
            if (k == 15) btnRaw = 1'b0;
        end

        // Bouncing contact never accepted.
        for (int r = 0; r < 5; r++) begin
            btnRaw = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge MCLK);
                check_eq("bounce_pulse", {31'd0, pulseOut}, 32'd1);
                check_eq("bounce_pressed", {31'd0, pressed}, 32'd0);
            end
            btnRaw = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(posedge MCLK);
                check_eq("bounce_pulse", {31'd0, pulseOut}, 32'd1);
                check_eq("bounce_pressed", {31'd0, pressed}, 32'd0);
            end
        end
        settle(1'b0, 10);

        // Long hold of 60 edges with auto-repeat.
        btnRaw = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge MCLK);
            check_eq("hold_pulse", {31'd0, pulseOut}, {31'd0, !exp_low_hold(k - 1)});
            check_eq("hold_repeating", {31'd0, repeating}, {31'd0, AR && (k - 1 >= 26)});
        end
        settle(1'b0, 12);
        check_eq("hold_released", {31'd0, pressed}, 32'd0);

        // Short release glitch while held restarts the repeat delay.
        btnRaw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge MCLK);
            check_eq("glitch_pulse", {31'd0, pulseOut},
                     {31'd0, !((k - 1 == 6) || (k - 1 == 7) || (AR && (k - 1 == 35 || k - 1 == 36)))});
            check_eq("glitch_pressed", {31'd0, pressed}, {31'd0, k - 1 >= 6});
            if (k == 11) btnRaw = 1'b0;
            if (k == 13) btnRaw = 1'b1;
        end
        settle(1'b0, 12);

        // Reset in the middle of a pulse while the button stays held.
        btnRaw = 1'b1;
        repeat (RST_AT + 1) @(posedge MCLK);
        check_eq("pre_rst_pulse", {31'd0, pulseOut}, 32'd0);
        pulse_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge MCLK);
            check_eq("post_rst_pulse", {31'd0, pulseOut}, {31'd0, !(k - 1 == 6 || k - 1 == 7)});
            check_eq("post_rst_pressed", {31'd0, pressed}, {31'd0, k - 1 >= 6});
        end
        settle(1'b0, 12);

        // Randomized activity checked against the model.
        for (int i = 0; i < 160; i++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = (v && $urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            btnRaw = v;
            repeat (len) @(posedge MCLK);
            if ($urandom_range(0, 24) == 0) pulse_reset();
        end
        settle(1'b0, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream conditioner for the clock's setting buttons. It converts a raw, bouncy, active-high push-button into a clean active-low pulse train. That train feeds the plus/minus inputs of the digit counters, which count on a falling edge of the line (low level sampled after a high level). Each button has its own instance. A press yields one pulse after debounce; a held button yields auto-repeat pulses.

Parameters:
SYNC_STAGES, 2, synchroniser flops on btnRaw (min 2)
DEBOUNCE_CYCLES, 250000, MCLK cycles of stable level to accept press/release (min 2)
REPEAT_DELAY, 25000000, MCLK cycles from accepted press to first repeat pulse
REPEAT_PERIOD, 5000000, MCLK cycles between repeat pulses; must be >= PULSE_CYCLES+1
PULSE_CYCLES, 2, MCLK cycles pulseOut is held low per event (min 1)
CNT_WIDTH, 25, width of the shared timing counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)-1

Ports:
MCLK  input  1  system clock; all registers update on its falling edge
resetSignal  input  1  asynchronous active-low reset
btnRaw  input  1  raw button, 1 = pressed, asynchronous to MCLK
pulseOut  output  1  idles 1; driven 0 for PULSE_CYCLES cycles per press/repeat event
pressed  output  1  debounced button level
repeating  output  1  1 while in auto-repeat phase

Behaviour:
- Reset (async, resetSignal=0): sync flops 0, state IDLE, counter 0, pulse counter 0, pulseOut=1, pressed=0, repeating=0. Reset mid-pulse raises pulseOut immediately. Reset mid-hold requires a fresh debounce after release.
- btnSync = btnRaw after SYNC_STAGES flops. The FSM uses only btnSync.
- Timing rule: on entry to any timed state the counter is 0. On each edge: if counter == LIMIT-1, take the timed transition; else counter++. A timed transition therefore fires LIMIT edges after entry.
- IDLE: btnSync=1 -> PRESS_DB.
- PRESS_DB (LIMIT=DEBOUNCE_CYCLES):
  - btnSync=0 -> IDLE; glitch, no pulse.
  - Timeout with btnSync=1 -> HELD; pressed=1; pulse request.
- HELD (LIMIT=REPEAT_DELAY):
  - btnSync=0 -> RELEASE_DB.
  - Timeout -> REPEAT; repeating=1; pulse request.
- REPEAT (LIMIT=REPEAT_PERIOD):
  - btnSync=0 -> RELEASE_DB.
  - Timeout -> stay in REPEAT; counter 0; pulse request.
- RELEASE_DB (LIMIT=DEBOUNCE_CYCLES):
  - btnSync=1 -> HELD; counter 0; repeating=0; no pulse.
  - Timeout -> IDLE; pressed=0; repeating=0.
- Leaving REPEAT for any state clears repeating.
- Pulse generator: a request loads the pulse counter with PULSE_CYCLES. pulseOut=0 while the pulse counter is non-zero, decrementing each edge. pulseOut goes low at the same edge as the request. A request while a pulse is active is dropped; the parameter constraint prevents this in normal operation.
- Latency: let E0 be the first edge sampling btnRaw=1. pulseOut goes low at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES.
  - First repeat pulse: REPEAT_DELAY edges after the press pulse.
  - Later repeat pulses: every REPEAT_PERIOD edges.
- pulseOut is high for at least 1 cycle between pulses, so each pulse is a distinct falling edge for the consumer.

Optional Feature:
AUTOREPEAT_EN
- Defined: full behaviour above.
- Undefined: REPEAT state absent. HELD has no timeout and exits only via btnSync=0 -> RELEASE_DB. Exactly one pulse per accepted press. repeating is tied to 0.

Test Plan:
(bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, PULSE_CYCLES=2, AUTOREPEAT_EN defined)
- Clean press at edge E0, held 15 cycles, then released -> pulseOut=0 exactly at edges E0+6 and E0+7; pressed=1 from E0+6; no further pulse; pressed=0 4 edges after btnSync drops.
- Bounce: btnRaw 1 for 3 cycles, 0 for 2 cycles, repeated 5 times, then 0 -> pulseOut stays 1 throughout; pressed stays 0.
- Long hold of 60 cycles from E0 -> pulses start at E0+6, E0+26, E0+34, E0+42, E0+50, E0+58; repeating=1 from E0+26 until RELEASE_DB is entered.
- Release glitch: 2-cycle 0 on btnRaw while in HELD -> returns to HELD with no pulse; next repeat comes 20 edges after re-entry.
- resetSignal pulsed low mid-pulse while in REPEAT -> pulseOut=1, pressed=0, repeating=0 immediately; button still held -> new press pulse 4 edges after PRESS_DB entry.
- AUTOREPEAT_EN undefined, same 60-cycle hold -> single pulse at E0+6; repeating always 0.
